// File: rtl/ps2_cmd_scheduler.sv
// Host-side PS/2 command sequencer: round-robin arbitration over NREQ requesters,
// byte transmit handshake, ACK/RESEND handling, and per-requester ack/err reporting.
module ps2_cmd_scheduler #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 20000,
  parameter int MAX_RETRY = 3
) (
  input  logic              slowClk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   two_byte,
  input  logic [8*NREQ-1:0] cmd_byte0,
  input  logic [8*NREQ-1:0] cmd_byte1,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [7:0]        tx_command,
  output logic              tx_send,
  input  logic              tx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int BSL_W = PTR_W + 3;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [7:0] KBD_ACK    = 8'hFA;
  localparam logic [7:0] KBD_RESEND = 8'hFE;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND     = 3'd1;
  localparam logic [2:0] ST_WAIT_TX  = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  logic [2:0]       state_q,   state_d;
  logic [PTR_W-1:0] ptr_q,     ptr_d;
  logic [PTR_W-1:0] grant_q,   grant_d;
  logic             two_q,     two_d;
  logic [7:0]       byte1_q,   byte1_d;
  logic [7:0]       cmd_q,     cmd_d;
  logic             idx_q,     idx_d;
  logic [RTY_W-1:0] retry_q,   retry_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [NREQ-1:0]  ack_q,     ack_d;
  logic [NREQ-1:0]  err_q,     err_d;

  // Round-robin search: first set request at or after the pointer, wrapping.
  logic [PTR_W-1:0] rr_grant;
  logic [PTR_W-1:0] rr_cand;
  logic             rr_valid;
  int               rr_idx;
  logic [BSL_W-1:0] rr_bsel;

  // NOTE: every signal written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    rr_grant = ptr_q;
    rr_valid = 1'b0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      rr_cand = PTR_W'(rr_idx);
      if (!rr_valid && req[rr_cand]) begin
        rr_valid = 1'b1;
        rr_grant = rr_cand;
      end
    end
  end

  assign rr_bsel = {rr_grant, 3'b000};

  logic [PTR_W-1:0] ptr_next;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_hit;

  assign ptr_next = (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + PTR_W'(1);
  assign tmo_inc  = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
  assign tmo_hit  = (tmo_inc == TMO_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    two_d   = two_q;
    byte1_d = byte1_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    ack_d   = '0;
    err_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          two_d   = two_byte[rr_grant];
          cmd_d   = cmd_byte0[rr_bsel +: 8];
          byte1_d = cmd_byte1[rr_bsel +: 8];
          idx_d   = 1'b0;
          retry_d = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        tmo_d   = '0;
        state_d = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          tmo_d   = '0;
          state_d = ST_WAIT_ACK;
        end else if (tmo_hit) begin
          err_d[grant_q] = 1'b1;
          state_d        = ST_FINISH;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      // A qualified ACK/RESEND wins over a timeout expiring in the same cycle;
      // any other received byte (e.g. a scancode) just lets the timer run.
      ST_WAIT_ACK: begin
        if (rx_valid && rx_data == KBD_ACK) begin
          if (!idx_q && two_q) begin
            cmd_d   = byte1_q;
            idx_d   = 1'b1;
            retry_d = '0;
            state_d = ST_SEND;
          end else begin
            ack_d[grant_q] = 1'b1;
            state_d        = ST_FINISH;
          end
        end else if (rx_valid && rx_data == KBD_RESEND) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_SEND;
          end else begin
            err_d[grant_q] = 1'b1;
            state_d        = ST_FINISH;
          end
        end else if (tmo_hit) begin
          err_d[grant_q] = 1'b1;
          state_d        = ST_FINISH;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_FINISH: begin
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge slowClk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      two_q   <= 1'b0;
      byte1_q <= 8'h00;
      cmd_q   <= 8'h00;
      idx_q   <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      two_q   <= two_d;
      byte1_q <= byte1_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign tx_send    = (state_q == ST_SEND);
  assign tx_command = cmd_q;
  assign ack        = ack_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Directed bench for ps2_cmd_scheduler: per-cycle vector table for the basic
// transactions, hand-written sequences for retry, timeout, fairness and reset.
module tb_ps2_cmd_scheduler;

  localparam int NREQ      = 2;
  localparam int TIMEOUT   = 20;
  localparam int MAX_RETRY = 3;

  logic        slowClk = 1'b0;
  logic        reset;
  logic [1:0]  req, two_byte;
  logic [15:0] cmd_byte0, cmd_byte1;
  logic [1:0]  ack, err;
  logic        busy, tx_send, tx_done, rx_valid;
  logic [7:0]  tx_command, rx_data;

  int checks = 0;
  int errors = 0;
  int send_cnt = 0;
  int base;

  ps2_cmd_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .slowClk(slowClk), .reset(reset), .req(req), .two_byte(two_byte),
    .cmd_byte0(cmd_byte0), .cmd_byte1(cmd_byte1), .ack(ack), .err(err),
    .busy(busy), .tx_command(tx_command), .tx_send(tx_send), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 slowClk = ~slowClk;

  always @(negedge slowClk) if (tx_send === 1'b1) send_cnt++;

  typedef struct {
    logic [1:0]  req, tb;
    logic [15:0] b0, b1;
    logic        txd, rxv;
    logic [7:0]  rxd;
    logic        e_busy, e_send, e_chk;
    logic [7:0]  e_cmd;
    logic [1:0]  e_ack, e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] tbv,
                              input logic [15:0] b0v, input logic [15:0] b1v,
                              input logic txd, input logic rxv, input logic [7:0] rxd,
                              input logic eb, input logic es, input logic ec,
                              input logic [7:0] ecmd, input logic [1:0] ea,
                              input logic [1:0] ee);
    vec_t v;
    v.req = rq; v.tb = tbv; v.b0 = b0v; v.b1 = b1v;
    v.txd = txd; v.rxv = rxv; v.rxd = rxd;
    v.e_busy = eb; v.e_send = es; v.e_chk = ec; v.e_cmd = ecmd;
    v.e_ack = ea; v.e_err = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge slowClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // From a SEND cycle: transmitter completes, then keyboard replies.
  task automatic tx_then_reply(input logic [7:0] reply);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = reply;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Single-byte 0xF4 on requester 0: tx_done 5 cycles after tx_send, ACK 10 later.
    vq.push_back(mk(2'b01, 2'b00, 16'h00F4, 16'h0000, 0, 0, 8'h00, 1, 1, 1, 8'hF4, 2'b00, 2'b00));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(2'b01, 2'b00, 16'h00F4, 16'h0000, 0, 0, 8'h00, 1, 0, 1, 8'hF4, 2'b00, 2'b00));
    vq.push_back(mk(2'b01, 2'b00, 16'h00F4, 16'h0000, 1, 0, 8'h00, 1, 0, 1, 8'hF4, 2'b00, 2'b00));
    for (int i = 0; i < 9; i++)
      vq.push_back(mk(2'b01, 2'b00, 16'h00F4, 16'h0000, 0, 0, 8'h00, 1, 0, 1, 8'hF4, 2'b00, 2'b00));
    vq.push_back(mk(2'b01, 2'b00, 16'h00F4, 16'h0000, 0, 1, 8'hFA, 1, 0, 1, 8'hF4, 2'b01, 2'b00));
    vq.push_back(mk(2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 2'b00));
    // LED 0xED/0x07 on requester 1; byte1 input changed after the grant, scancode
    // before the first ACK, and a stray 0xFA during WAIT_TX.
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h0700, 0, 0, 8'h00, 1, 1, 1, 8'hED, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 0, 0, 8'h00, 1, 0, 1, 8'hED, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 1, 0, 8'h00, 1, 0, 1, 8'hED, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 0, 1, 8'h1C, 1, 0, 1, 8'hED, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 0, 1, 8'hFA, 1, 1, 1, 8'h07, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 0, 1, 8'hFA, 1, 0, 1, 8'h07, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 1, 0, 8'h00, 1, 0, 1, 8'h07, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 2'b10, 16'hED00, 16'h5500, 0, 1, 8'hFA, 1, 0, 1, 8'h07, 2'b10, 2'b00));
    vq.push_back(mk(2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 2'b00));

    reset = 1'b0; req = 2'b11; two_byte = 2'b00;
    cmd_byte0 = 16'h2211; cmd_byte1 = 16'h0000;
    tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset held with both requests pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", 32'({busy, tx_send, tx_command, ack, err}), 32'd0);
    end
    reset = 1'b1;
    tick();
    check("reset_first_grant", 32'({busy, tx_send, tx_command}), 32'({1'b1, 1'b1, 8'h11}));
    req = 2'b00;
    tx_then_reply(8'hFA);
    check("reset_first_ack", 32'({ack, err}), 32'b0100);
    tick();
    check("reset_first_idle", 32'({busy, ack, err}), 32'd0);

    // Table-driven cycles.
    for (int i = 0; i < vq.size(); i++) begin
      req = vq[i].req; two_byte = vq[i].tb;
      cmd_byte0 = vq[i].b0; cmd_byte1 = vq[i].b1;
      tx_done = vq[i].txd; rx_valid = vq[i].rxv; rx_data = vq[i].rxd;
      tick();
      check($sformatf("vec%0d", i),
            32'({busy, tx_send, vq[i].e_chk ? tx_command : 8'h00, ack, err}),
            32'({vq[i].e_busy, vq[i].e_send, vq[i].e_chk ? vq[i].e_cmd : 8'h00,
                 vq[i].e_ack, vq[i].e_err}));
    end
    tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Four RESENDs exhaust MAX_RETRY=3 -> err[0] after four sends.
    req = 2'b01; two_byte = 2'b00; cmd_byte0 = 16'h00FF;
    base = send_cnt;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("resend_cmd", 32'({tx_send, tx_command}), 32'({1'b1, 8'hFF}));
      tx_then_reply(8'hFE);
    end
    check("resend_err", 32'({ack, err}), 32'b0001);
    req = 2'b00;
    tick();
    check("resend_sends", 32'(send_cnt - base), 32'd4);

    // One RESEND then ACK -> two sends, ack[0].
    req = 2'b01;
    base = send_cnt;
    tick();
    tx_then_reply(8'hFE);
    check("retry_resend", 32'({tx_send, tx_command}), 32'({1'b1, 8'hFF}));
    tx_then_reply(8'hFA);
    check("retry_ack", 32'({ack, err}), 32'b0100);
    req = 2'b00;
    tick();
    check("retry_sends", 32'(send_cnt - base), 32'd2);

    // No reply: err[1] exactly TIMEOUT cycles after entering WAIT_ACK.
    req = 2'b10; cmd_byte0 = 16'hF300;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      check("timeout_waiting", 32'({busy, ack, err}), 32'b10000);
    end
    tick();
    check("timeout_err", 32'({ack, err}), 32'b0010);
    req = 2'b00;
    tick();

    // ACK arriving in the expiry cycle wins.
    req = 2'b10;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) tick();
    rx_valid = 1'b1; rx_data = 8'hFA;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
    check("tie_ack_wins", 32'({ack, err}), 32'b1000);
    req = 2'b00;
    tick();

    // Continuous dual request alternates 0,1,0,1 with one IDLE cycle between.
    req = 2'b11; cmd_byte0 = 16'h2211;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("fair_grant", 32'(tx_command), (t % 2 == 0) ? 32'h11 : 32'h22);
      tx_then_reply(8'hFA);
      check("fair_ack", 32'({ack, err}), (t % 2 == 0) ? 32'b0100 : 32'b1000);
      if (t == 3) req = 2'b00;
      tick();
      check("fair_gap", 32'({busy, ack, err}), 32'd0);
    end

    // Reset during WAIT_ACK aborts silently.
    req = 2'b01; cmd_byte0 = 16'h0011;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("midrst_waiting", 32'({busy, tx_send}), 32'b10);
    reset = 1'b0; req = 2'b00;
    tick();
    check("midrst_outputs", 32'({busy, tx_send, tx_command, ack, err}), 32'd0);
    reset = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hFA;
    for (int i = 0; i < 3; i++) begin
      tick();
      rx_valid = 1'b0;
      check("midrst_quiet", 32'({busy, tx_send, ack, err}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
